// File: rtl/hc128_stream_core_if.sv
// hc128_stream_core_if
//   Host/consumer bundle of the HC-128 keystream core.
//   key/iv/init : host loads a new key/IV with a one-cycle init pulse
//   ready       : core finished key setup and is producing keystream
//   ks_data     : OUT_WORDS x 32-bit beat, earliest word in bits [31:0]
//   ks_valid    : beat present; ks_ready: consumer takes it on valid&ready
// Modports: master = host/consumer side, slave = core side.
interface hc128_stream_core_if #(
  parameter int OUT_WORDS = 1
);
  logic [127:0]            key;
  logic [127:0]            iv;
  logic                    init;
  logic                    ready;
  logic [32*OUT_WORDS-1:0] ks_data;
  logic                    ks_valid;
  logic                    ks_ready;

  modport master (
    output key, iv, init, ks_ready,
    input  ready, ks_data, ks_valid
  );

  modport slave (
    input  key, iv, init, ks_ready,
    output ready, ks_data, ks_valid
  );
endinterface

// File: rtl/hc128_stream_core.sv
// hc128_stream_core
//   HC-128 keystream generator: key/IV expansion over a 16-word sliding
//   window, 1024-step table warm-up, then one keystream word per clock
//   while the output path has room.  Words are gathered into OUT_WORDS-wide
//   beats and delivered over a valid/ready handshake.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : hc128_stream_core_if.slave (key, iv, init, ready,
//             ks_data, ks_valid, ks_ready)
// Every cipher step (expansion, warm-up or generation) takes one clock,
// well inside MAX_STEP_CYCLES.

// One output lane: assembly word plus the output word it feeds.
module hc128_ks_lane (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,     // drop partial and pending data
  input  logic        load,      // current step's word lands in this lane
  input  logic [31:0] word,
  input  logic        move,      // assembled beat moves to output register
  output logic [31:0] out_word
);
  logic [31:0] asm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q    <= '0;
      out_word <= '0;
    end else if (flush) begin
      asm_q    <= '0;
      out_word <= '0;
    end else begin
      // move copies the completed beat while load may start the next one
      if (load) asm_q    <= word;
      if (move) out_word <= asm_q;
    end
  end
endmodule

module hc128_stream_core #(
  parameter int OUT_WORDS       = 1,
  parameter int MAX_STEP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  hc128_stream_core_if.slave  bus
);
  localparam int CW = $clog2(OUT_WORDS + 1);

  if (!(OUT_WORDS == 1 || OUT_WORDS == 2 || OUT_WORDS == 4) || MAX_STEP_CYCLES < 1)
  begin : g_param_check
    $error("hc128_stream_core: OUT_WORDS must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, WARMUP, GEN} state_t;

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] f1(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f2(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] g1(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (rotr(x, 10) ^ rotr(z, 23)) + rotr(y, 8);
  endfunction

  // rotl(n) == rotr(32-n)
  function automatic logic [31:0] g2(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (rotr(x, 22) ^ rotr(z, 9)) + rotr(y, 24);
  endfunction

  // ---------------------------------------------------------------- state
  state_t                         state_q, state_d;
  logic [10:0]                    cnt_q;      // expansion i / step counter
  logic [15:0][31:0]              win_q;      // W[i-16] at [0] .. W[i-1] at [15]
  logic [31:0]                    p_mem [512];
  logic [31:0]                    q_mem [512];
  logic [CW-1:0]                  asm_cnt_q;
  logic                           ks_valid_q;
  logic [OUT_WORDS-1:0][31:0]     ks_data;

  logic exp_act, warm_act, gen_act, ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.init) begin
      state_d = EXPAND;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        EXPAND:  if (cnt_q == 11'd1279) state_d = WARMUP;
        WARMUP:  if (cnt_q == 11'd1023) state_d = GEN;
        GEN:     state_d = GEN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    exp_act  = (state_q == EXPAND);
    warm_act = (state_q == WARMUP);
    gen_act  = (state_q == GEN);
    ready    = (state_q == GEN);
  end

  // ---------------------------------------------------------------- control
  // init wins over everything: no table write, no step, no output move.
  logic exp_run, warm_run, gen_on, asm_full, move, gen_step, step;

  assign exp_run  = exp_act  & ~bus.init;
  assign warm_run = warm_act & ~bus.init;
  assign gen_on   = gen_act  & ~bus.init;
  assign asm_full = (asm_cnt_q == CW'(OUT_WORDS));
  // full beat can leave when the output slot is empty or being taken now
  assign move     = gen_on & asm_full & (~ks_valid_q | bus.ks_ready);
  // generation stalls only while a full beat is waiting behind a held one
  assign gen_step = gen_on & (~asm_full | move);
  assign step     = warm_run | gen_step;

  // ---------------------------------------------------------------- expansion
  logic [31:0] w_new;
  assign w_new = f2(win_q[14]) + win_q[9] + f1(win_q[1]) + win_q[0] + {21'd0, cnt_q};

  // Key/IV live only in the window, so later key/iv changes are ignored.
  always_ff @(posedge clk) begin
    if (bus.init)     win_q <= {bus.iv, bus.iv, bus.key, bus.key};
    else if (exp_run) win_q <= {w_new, win_q[15:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cnt_q <= '0;
    else if (bus.init) cnt_q <= 11'd16;   // W[0..15] are the window load
    else if (exp_run)  cnt_q <= (cnt_q == 11'd1279) ? 11'd0 : cnt_q + 11'd1;
    else if (step)     cnt_q <= {1'b0, cnt_q[9:0] + 10'd1};  // wraps mod 1024
  end

  // ---------------------------------------------------------------- step datapath
  // cnt_q[9] selects the table being updated; h looks up the other table.
  logic        tsel;
  logic [8:0]  j, a3, a10, a511, a12, h_lo, h_hi;
  logic [31:0] t_j, t_3, t_10, t_511, t_12, g, h, upd, s;

  assign tsel = cnt_q[9];
  assign j    = cnt_q[8:0];
  assign a3   = j - 9'd3;
  assign a10  = j - 9'd10;
  assign a511 = j + 9'd1;          // j - 511 mod 512
  assign a12  = j - 9'd12;

  assign t_j   = tsel ? q_mem[j]    : p_mem[j];
  assign t_3   = tsel ? q_mem[a3]   : p_mem[a3];
  assign t_10  = tsel ? q_mem[a10]  : p_mem[a10];
  assign t_511 = tsel ? q_mem[a511] : p_mem[a511];
  assign t_12  = tsel ? q_mem[a12]  : p_mem[a12];

  // byte 0 indexes the low half, byte 2 the high half of the other table
  assign h_lo = 9'(t_12 & 32'h0000_00ff);
  assign h_hi = 9'((t_12 >> 16) & 32'h0000_00ff) | 9'h100;

  assign g   = tsel ? g2(t_3, t_10, t_511) : g1(t_3, t_10, t_511);
  assign h   = tsel ? (p_mem[h_lo] + p_mem[h_hi]) : (q_mem[h_lo] + q_mem[h_hi]);
  assign upd = t_j + g;
  assign s   = h ^ upd;            // keystream word; also the warm-up entry

  // ---------------------------------------------------------------- table writes
  logic        p_we, q_we;
  logic [8:0]  p_wa, q_wa;
  logic [31:0] p_wd, q_wd;

  always_comb begin
    p_we = 1'b0;
    q_we = 1'b0;
    p_wa = j;
    q_wa = j;
    p_wd = warm_run ? s : upd;
    q_wd = warm_run ? s : upd;
    if (exp_run) begin
      p_wd = w_new;
      q_wd = w_new;
      if (cnt_q >= 11'd256 && cnt_q < 11'd768) begin
        p_we = 1'b1;
        p_wa = 9'(cnt_q - 11'd256);
      end else if (cnt_q >= 11'd768) begin
        q_we = 1'b1;
        q_wa = 9'(cnt_q - 11'd768);
      end
    end else if (step) begin
      p_we = ~tsel;
      q_we = tsel;
    end
  end

  always_ff @(posedge clk) begin
    if (p_we) p_mem[p_wa] <= p_wd;
    if (q_we) q_mem[q_wa] <= q_wd;
  end

  // ---------------------------------------------------------------- output path
  logic [CW-1:0] lane;
  assign lane = move ? '0 : asm_cnt_q;   // a moving beat frees lane 0 at once

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      asm_cnt_q <= '0;
    else if (bus.init) asm_cnt_q <= '0;
    else if (gen_step) asm_cnt_q <= move ? CW'(1) : asm_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        ks_valid_q <= 1'b0;
    else if (bus.init)                   ks_valid_q <= 1'b0;
    else if (move)                       ks_valid_q <= 1'b1;
    else if (ks_valid_q & bus.ks_ready)  ks_valid_q <= 1'b0;
  end

  for (genvar k = 0; k < OUT_WORDS; k++) begin : g_lane
    hc128_ks_lane u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (bus.init),
      .load     (gen_step & (lane == CW'(k))),
      .word     (s),
      .move     (move),
      .out_word (ks_data[k])
    );
  end

  assign bus.ready    = ready;
  assign bus.ks_valid = ks_valid_q;
  assign bus.ks_data  = ks_data;
endmodule

// File: tb/tb_hc128_stream_core.sv
module tb_hc128_stream_core;
  localparam int MSC   = 4;
  localparam int BOUND = MSC * (1280 + 1024) + 8;
  localparam int NM    = 2100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hc128_stream_core_if #(.OUT_WORDS(1)) i1 ();
  hc128_stream_core_if #(.OUT_WORDS(4)) i4 ();

  hc128_stream_core #(.OUT_WORDS(1), .MAX_STEP_CYCLES(MSC)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(i1));
  hc128_stream_core #(.OUT_WORDS(4), .MAX_STEP_CYCLES(MSC)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(i4));

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    int           idx;   // word position in the stream
    logic [31:0]  exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------- reference model
  logic [31:0] ww [1280];
  logic [31:0] mp [512];
  logic [31:0] mq [512];
  logic [31:0] mw [NM];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] mf1(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] mf2(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  task automatic m_step(input int i, input bit warm, output logic [31:0] s);
    int j;
    logic [31:0] x, h;
    j = i % 512;
    if ((i % 1024) < 512) begin
      x = mp[(j - 12) & 511];
      h = mq[x[7:0]] + mq[256 + x[23:16]];
      mp[j] = mp[j] + ((rotr(mp[(j - 3) & 511], 10) ^ rotr(mp[(j - 511) & 511], 23))
                       + rotr(mp[(j - 10) & 511], 8));
      s = h ^ mp[j];
      if (warm) mp[j] = s;
    end else begin
      x = mq[(j - 12) & 511];
      h = mp[x[7:0]] + mp[256 + x[23:16]];
      mq[j] = mq[j] + ((rotr(mq[(j - 3) & 511], 22) ^ rotr(mq[(j - 511) & 511], 9))
                       + rotr(mq[(j - 10) & 511], 24));
      s = h ^ mq[j];
      if (warm) mq[j] = s;
    end
  endtask

  task automatic m_run(input logic [127:0] k, input logic [127:0] v, input int n);
    logic [31:0] s;
    for (int i = 0; i < 8; i++) begin
      ww[i]     = k[32*(i%4) +: 32];
      ww[i + 8] = v[32*(i%4) +: 32];
    end
    for (int i = 16; i < 1280; i++)
      ww[i] = mf2(ww[i-2]) + ww[i-7] + mf1(ww[i-15]) + ww[i-16] + i;
    for (int i = 0; i < 512; i++) begin
      mp[i] = ww[i + 256];
      mq[i] = ww[i + 768];
    end
    for (int i = 0; i < 1024; i++) m_step(i, 1'b1, s);
    for (int i = 0; i < n; i++) begin
      m_step(i, 1'b0, s);
      mw[i] = s;
    end
  endtask

  // ---------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input logic [127:0] k, input logic [127:0] v, input logic in);
    i1.key = k; i1.iv = v; i1.init = in;
    i4.key = k; i4.iv = v; i4.init = in;
  endtask

  // init pulse, then scramble key/iv to show they are only sampled on init
  task automatic pulse_init(input logic [127:0] k, input logic [127:0] v);
    host(k, v, 1'b1);
    tick();
    host(~k ^ 128'h5a5a, v ^ 128'h1234_5678, 1'b0);
  endtask

  task automatic wait_ready(input string name);
    int c;
    c = 0;
    while (!i1.ready && c < BOUND + 20) begin
      tick();
      c++;
    end
    chk({name, "_latency_ok"}, 128'(c <= BOUND), 128'd1);
    chk({name, "_ready4"}, 128'(i4.ready), 128'd1);
  endtask

  // take n words from dut1 with ks_ready high, compare with model words
  task automatic collect1(input string name, input int n);
    int c;
    i1.ks_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      c = 0;
      while (!i1.ks_valid && c < 20) begin tick(); c++; end
      chk($sformatf("%s_w%0d", name, i), 128'(i1.ks_data), 128'(mw[i]));
      tick();
    end
  endtask

  task automatic apply_table(input vec_t tbl[4], input string name);
    int c;
    i1.ks_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = 0;
      while (!i1.ks_valid && c < 20) begin tick(); c++; end
      chk($sformatf("%s_kat%0d", name, tbl[i].idx), 128'(i1.ks_data), 128'(tbl[i].exp));
      tick();
    end
  endtask

  // ---------------------------------------------------------- test
  initial begin
    vec_t tbl[4];
    int c, c1, c4, got, idx, unstable, early, drops, e0;
    logic stalled;
    logic [31:0] held;
    logic r;

    tbl[0] = '{128'h0, 128'h0, 0, 32'h73150082};
    tbl[1] = '{128'h0, 128'h0, 1, 32'h3bfd03a0};
    tbl[2] = '{128'h0, 128'h0, 2, 32'hfb2fd77f};
    tbl[3] = '{128'h0, 128'h0, 3, 32'haa63af0e};

    host(128'h0, 128'h0, 1'b0);
    i1.ks_ready = 1'b0;
    i4.ks_ready = 1'b0;

    // reset values
    repeat (3) tick();
    chk("rst_ready1", 128'(i1.ready), 128'd0);
    chk("rst_valid1", 128'(i1.ks_valid), 128'd0);
    chk("rst_data1", 128'(i1.ks_data), 128'd0);
    chk("rst_valid4", 128'(i4.ks_valid), 128'd0);
    chk("rst_data4", 128'(i4.ks_data), 128'd0);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("idle_ready1", 128'(i1.ready), 128'd0);
    chk("idle_valid1", 128'(i1.ks_valid), 128'd0);

    // zero key/iv
    m_run(128'h0, 128'h0, NM);
    pulse_init(tbl[0].key, tbl[0].iv);
    wait_ready("zero");

    c1 = -1; c4 = -1;
    for (int k = 0; k <= 24; k++) begin
      if (c1 < 0 && i1.ks_valid) c1 = k;
      if (c4 < 0 && i4.ks_valid) c4 = k;
      if (c1 >= 0 && c4 >= 0) break;
      tick();
    end
    chk("first_beat1_lat", 128'(c1 >= 0 && c1 <= 1*MSC + 4), 128'd1);
    chk("first_beat4_lat", 128'(c4 >= 0 && c4 <= 4*MSC + 4), 128'd1);
    chk("beat4_kat", 128'(i4.ks_data),
        {tbl[3].exp, tbl[2].exp, tbl[1].exp, tbl[0].exp});
    repeat (3) tick();
    chk("beat4_hold", 128'(i4.ks_data),
        {tbl[3].exp, tbl[2].exp, tbl[1].exp, tbl[0].exp});
    chk("beat4_hold_valid", 128'(i4.ks_valid), 128'd1);
    i4.ks_ready = 1'b1;
    tick();
    i4.ks_ready = 1'b0;
    c = 0;
    while (!i4.ks_valid && c < 20) begin tick(); c++; end
    chk("beat4_next", 128'(i4.ks_data), {mw[7], mw[6], mw[5], mw[4]});

    // dut1 table vectors, then random back-pressure continuing the stream
    apply_table(tbl, "zero");
    got = 0; idx = 4; c = 0; unstable = 0; stalled = 1'b0; held = '0;
    while (got < 2000 && c < 20000) begin
      if (stalled && (!i1.ks_valid || i1.ks_data !== held)) unstable++;
      r = 1'($urandom_range(0, 1));
      i1.ks_ready = r;
      if (i1.ks_valid && r) begin
        e0 = n_err;
        chk($sformatf("bp_w%0d", idx), 128'(i1.ks_data), 128'(mw[idx]));
        idx++;
        got++;
        if (n_err != e0) break;
      end
      stalled = i1.ks_valid && !r;
      held = i1.ks_data;
      tick();
      c++;
    end
    chk("bp_count", 128'(got), 128'd2000);
    chk("bp_stable", 128'(unstable), 128'd0);

    // re-init in GEN with a beat pending
    i1.ks_ready = 1'b0;
    c = 0;
    while (!i1.ks_valid && c < 20) begin tick(); c++; end
    chk("reinit_pending", 128'(i1.ks_valid), 128'd1);
    pulse_init(128'h1, 128'h0);
    chk("reinit_ready1", 128'(i1.ready), 128'd0);
    chk("reinit_valid1", 128'(i1.ks_valid), 128'd0);
    chk("reinit_valid4", 128'(i4.ks_valid), 128'd0);
    m_run(128'h1, 128'h0, 16);
    wait_ready("key1");
    collect1("key1", 8);

    // init during WARMUP, then during EXPAND, last one held high
    pulse_init(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h1111);
    early = 0;
    repeat (1500) begin tick(); early += int'(i1.ready); end
    pulse_init(128'hcafe, 128'hbeef_0000_0000_0000_0000_0000_0000_0001);
    repeat (200) begin tick(); early += int'(i1.ready); end
    host(128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100,
         128'h1f1e_1d1c_1b1a_1918_1716_1514_1312_1110, 1'b1);
    repeat (3) begin tick(); early += int'(i1.ready); end
    host(128'h0, 128'h0, 1'b0);
    chk("multi_no_early_ready", 128'(early), 128'd0);
    m_run(128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100,
          128'h1f1e_1d1c_1b1a_1918_1716_1514_1312_1110, 16);
    wait_ready("multi");
    drops = 0;
    fork
      collect1("multi", 8);
      repeat (30) begin tick(); drops += int'(!i1.ready); end
    join
    chk("multi_ready_steady", 128'(drops), 128'd0);

    // asynchronous reset in GEN
    i1.ks_ready = 1'b1;
    repeat (3) tick();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_ready1", 128'(i1.ready), 128'd0);
    chk("arst_valid1", 128'(i1.ks_valid), 128'd0);
    chk("arst_data1", 128'(i1.ks_data), 128'd0);
    chk("arst_data4", 128'(i4.ks_data), 128'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    c = 0;
    repeat (30) begin tick(); c += int'(i1.ready | i1.ks_valid | i4.ks_valid); end
    chk("arst_quiet", 128'(c), 128'd0);
    pulse_init(tbl[0].key, tbl[0].iv);
    wait_ready("arst");
    apply_table(tbl, "arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
